// File: rtl/rng_range.sv
// Draws a uniform value in 0..N-1 from an upstream 8-bit LFSR by rejection
// sampling: each draw is masked down to the smallest all-ones word that covers
// N-1 and retried on overflow. After MAX_TRIES rejected draws, the last
// candidate is folded back into range by subtracting N.
//
// state | meaning
// IDLE  | ready for a request
// DRAW  | lfsr_en strobed for one cycle; the LFSR advances at the end of it
// CHECK | masked LFSR value compared against N
// DONE  | result presented, held until rsp_ready
module rng_range #(
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_limit,
    input  logic [7:0] lfsr_q,
    output logic       lfsr_en,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_value,
    output logic       rsp_fallback
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    state_t     state_q;
    logic [7:0] limit_q;
    logic [7:0] mask_q;
    logic [7:0] tries_q;
    logic [7:0] value_q;
    logic       fallback_q;
    logic       req_ready_q;
    logic       rsp_valid_q;
    logic       lfsr_en_q;

    logic [7:0] mask_d;
    logic [7:0] cand;

    // Smear the highest set bit of N-1 downwards to get the covering mask.
    always_comb begin
        mask_d = req_limit - 8'd1;
        mask_d = mask_d | (mask_d >> 1);
        mask_d = mask_d | (mask_d >> 2);
        mask_d = mask_d | (mask_d >> 4);
    end

    // The LFSR has already advanced when CHECK samples it.
    always_comb cand = lfsr_q & mask_q;

    // Request sequencing; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            limit_q     <= 8'd0;
            mask_q      <= 8'd0;
            tries_q     <= 8'd0;
            value_q     <= 8'd0;
            fallback_q  <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
        end else begin
            lfsr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        limit_q     <= req_limit;
                        tries_q     <= 8'd0;
                        if (req_limit <= 8'd1) begin
                            // Only one possible result; no draw needed.
                            mask_q      <= 8'd0;
                            value_q     <= 8'd0;
                            fallback_q  <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mask_q    <= mask_d;
                            lfsr_en_q <= 1'b1;
                            state_q   <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (cand < limit_q) begin
                        value_q     <= cand;
                        fallback_q  <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (tries_q == LAST_TRY) begin
                        // mask+1 < 2N, so one subtraction lands in range.
                        value_q     <= cand - limit_q;
                        fallback_q  <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        tries_q   <= tries_q + 8'd1;
                        lfsr_en_q <= 1'b1;
                        state_q   <= DRAW;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_value    = value_q;
    assign rsp_fallback = fallback_q;
    assign lfsr_en      = lfsr_en_q;

endmodule

// File: tb/tb_rng_range.sv
// Bench for rng_range: two instances (MAX_TRIES 16 and 1), each fed by its own
// model of the upstream LFSR. Issued requests push expected results into
// per-instance queues; a monitor pops and compares when rsp_valid rises.
module tb_rng_range;

    typedef struct {
        int val;
        int fb;
        int draws;
        int lat;
        int acc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][7:0] req_limit;
    logic [1:0][7:0] lfsr_s;
    logic [1:0]      lfsr_en;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [1:0][7:0] rsp_value;
    logic [1:0]      rsp_fallback;

    logic [1:0] manual;
    logic [1:0] manual_val;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t cur[2];
    bit   seen[2];
    int   draws[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rng_range #(.MAX_TRIES(g == 0 ? 16 : 1)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_limit   (req_limit[g]),
            .lfsr_q      (lfsr_s[g]),
            .lfsr_en     (lfsr_en[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_ready   (rsp_ready[g]),
            .rsp_value   (rsp_value[g]),
            .rsp_fallback(rsp_fallback[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_next(logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Upstream LFSR: shift-left, taps 7,5,4,3, reset value 0xDA.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) lfsr_s[i] <= 8'hDA;
            else if (lfsr_en[i]) lfsr_s[i] <= lfsr_next(lfsr_s[i]);
        end
    end

    function automatic int max_tries(int i);
        return (i == 0) ? 16 : 1;
    endfunction

    function automatic exp_t mk(int v, int fb, int d, int l);
        exp_t e;
        e.val = v; e.fb = fb; e.draws = d; e.lat = l; e.acc = 0;
        return e;
    endfunction

    // Rejection sampling described directly: walk the LFSR sequence.
    function automatic exp_t model(logic [7:0] s0, int n, int maxt);
        exp_t e;
        logic [7:0] s;
        int m;
        int c;
        e = mk(0, 0, 0, 1);
        if (n <= 1) return e;
        m = 1;
        while (m < n - 1) m = m * 2 + 1;
        s = s0;
        c = 0;
        for (int t = 0; t < maxt; t++) begin
            s = lfsr_next(s);
            c = int'(s) & m;
            e.draws = t + 1;
            e.lat = 1 + 2 * (t + 1);
            if (c < n) begin
                e.val = c;
                return e;
            end
        end
        e.val = c - n;
        e.fb = 1;
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sb_size(int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic push(int i, exp_t e);
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    // Monitor: compare on the first DONE cycle, then check the result holds.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                seen[i] = 1'b0;
                draws[i] = 0;
            end else begin
                if (lfsr_en[i]) draws[i]++;
                check($sformatf("u%0d valid_and_ready", i), int'(rsp_valid[i] & req_ready[i]), 0);
                if (rsp_valid[i]) begin
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        if (sb_size(i) == 0) begin
                            check($sformatf("u%0d unexpected_rsp", i), 1, 0);
                            cur[i] = mk(int'(rsp_value[i]), int'(rsp_fallback[i]), 0, 0);
                        end else begin
                            cur[i] = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                            check($sformatf("u%0d value", i), int'(rsp_value[i]), cur[i].val);
                            check($sformatf("u%0d fallback", i), int'(rsp_fallback[i]), cur[i].fb);
                            check($sformatf("u%0d lfsr_en_pulses", i), draws[i], cur[i].draws);
                            check($sformatf("u%0d latency", i), cyc - cur[i].acc + 1, cur[i].lat);
                        end
                        draws[i] = 0;
                    end else begin
                        check($sformatf("u%0d value_hold", i), int'(rsp_value[i]), cur[i].val);
                        check($sformatf("u%0d fallback_hold", i), int'(rsp_fallback[i]), cur[i].fb);
                    end
                end else begin
                    seen[i] = 1'b0;
                end
            end
        end
    end

    // Consumer: random rsp_ready unless a test pins it.
    initial begin
        rsp_ready = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                rsp_ready[i] = manual[i] ? manual_val[i] : ($urandom_range(0, 2) == 0);
        end
    end

    task automatic issue(int i, int n, bit directed, exp_t dexp);
        exp_t e;
        int waited;
        waited = 0;
        while (!req_ready[i] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready[i]) begin
            check($sformatf("u%0d ready_timeout", i), 0, 1);
            return;
        end
        req_valid[i] = 1'b1;
        req_limit[i] = 8'(n);
        @(posedge clk);
        #1;
        e = directed ? dexp : model(lfsr_s[i], n, max_tries(i));
        e.acc = cyc;
        push(i, e);
        req_valid[i] = 1'b0;
        req_limit[i] = 8'($urandom);
    endtask

    task automatic drain(int i);
        int k;
        k = 0;
        while ((sb_size(i) != 0 || !req_ready[i]) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("u%0d drain", i), int'(sb_size(i) == 0 && req_ready[i]), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb0.delete();
        sb1.delete();
    endtask

    function automatic int pick_n();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 255;
            4: return $urandom_range(2, 9);
            default: return $urandom_range(2, 255);
        endcase
    endfunction

    task automatic rand_run(int i);
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(i, pick_n(), 1'b0, mk(0, 0, 0, 0));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_limit = '0;
        manual = 2'b00;
        manual_val = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d rst req_ready", i), int'(req_ready[i]), 0);
            check($sformatf("u%0d rst rsp_valid", i), int'(rsp_valid[i]), 0);
            check($sformatf("u%0d rst lfsr_en", i), int'(lfsr_en[i]), 0);
            check($sformatf("u%0d rst rsp_value", i), int'(rsp_value[i]), 0);
            check($sformatf("u%0d rst fallback", i), int'(rsp_fallback[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("u%0d ready_after_release", i), int'(req_ready[i]), 1);
        @(negedge clk);

        // Fresh LFSR: N=6 accepts 0xB5&7=5; MAX_TRIES=1 with N=5 falls back to 0.
        fork
            issue(0, 6, 1'b1, mk(5, 0, 1, 3));
            issue(1, 5, 1'b1, mk(0, 1, 1, 3));
        join
        drain(0);
        drain(1);

        // Fresh LFSR, N=5: 5 rejected, then 0x6B&7=3 accepted.
        pulse_reset();
        issue(0, 5, 1'b1, mk(3, 0, 2, 5));
        drain(0);

        // Degenerate limits: immediate response, no draw.
        issue(0, 0, 1'b1, mk(0, 0, 0, 1));
        drain(0);
        fork
            issue(0, 1, 1'b1, mk(0, 0, 0, 1));
            issue(1, 1, 1'b1, mk(0, 0, 0, 1));
        join
        drain(0);
        drain(1);

        // Result held while the consumer stalls; req_valid pulses ignored.
        @(negedge clk);
        manual[0] = 1'b1;
        manual_val[0] = 1'b0;
        @(negedge clk);
        issue(0, 3, 1'b0, mk(0, 0, 0, 0));
        k = 0;
        while (!rsp_valid[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold reached_done", int'(rsp_valid[0]), 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid[0] = c[0];
            check("hold req_ready", int'(req_ready[0]), 0);
            check("hold rsp_valid", int'(rsp_valid[0]), 1);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        manual_val[0] = 1'b1;
        @(posedge clk);
        #1;
        check("release rsp_valid", int'(rsp_valid[0]), 0);
        check("release req_ready", int'(req_ready[0]), 1);
        @(negedge clk);
        manual[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("after_release lfsr_en", int'(lfsr_en[0]), 0);
            check("after_release rsp_valid", int'(rsp_valid[0]), 0);
        end

        // Reset during CHECK abandons the request.
        issue(0, 200, 1'b0, mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset rsp_valid", int'(rsp_valid[0]), 0);
        check("mid_reset rsp_value", int'(rsp_value[0]), 0);
        check("mid_reset fallback", int'(rsp_fallback[0]), 0);
        check("mid_reset lfsr_en", int'(lfsr_en[0]), 0);
        check("mid_reset req_ready", int'(req_ready[0]), 0);
        sb0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset req_ready", int'(req_ready[0]), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("post_reset rsp_valid", int'(rsp_valid[0]), 0);
            check("post_reset lfsr_en", int'(lfsr_en[0]), 0);
        end

        // Randomized traffic on both instances.
        @(negedge clk);
        fork
            rand_run(0);
            rand_run(1);
        join
        drain(0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_range.md
RNG_RANGE -- requirements
Module: rng_range

Interface
REQ-001 Parameter MAX_TRIES, default 16 (legal 1..255); max LFSR draws per request before fallback.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  1  roll request.
REQ-005 req_ready  out  1  block accepts a request; high only in IDLE.
REQ-006 req_limit  in  8  exclusive upper bound N; result range is 0..N-1.
REQ-007 lfsr_q  in  8  current state of the upstream 8-bit LFSR.
REQ-008 lfsr_en  out  1  advance strobe to the upstream LFSR; one cycle per draw.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer takes result.
REQ-011 rsp_value  out  8  result, always < N (0 when N<=1).
REQ-012 rsp_fallback  out  1  result produced by the fallback path.

Function
REQ-013 States SHALL be IDLE, DRAW, CHECK, DONE; no other reachable states.
REQ-014 Request SHALL be accepted on a rising edge with req_valid=1 in IDLE; req_limit is latched then; later input changes have no effect.
REQ-015 At acceptance, mask SHALL be the smallest 2^k-1 >= N-1 (N=2 -> 0x01, N=6 -> 0x07, N=100 -> 0x7F, N=255 -> 0xFF); try counter cleared.
REQ-016 N=0 or N=1: IDLE -> DONE directly, rsp_value=0, rsp_fallback=0, lfsr_en never asserted.
REQ-017 N>=2: IDLE -> DRAW.
REQ-018 DRAW: lfsr_en=1 for exactly that cycle; next state CHECK; lfsr_en=0 in every other state.
REQ-019 CHECK: candidate = lfsr_q & mask (value after the advance); candidate < N -> DONE with rsp_value=candidate, rsp_fallback=0.
REQ-020 CHECK, candidate >= N, tries < MAX_TRIES-1: try counter +1, -> DRAW.
REQ-021 CHECK, candidate >= N, tries = MAX_TRIES-1: -> DONE, rsp_value = candidate - N (always < N since mask+1 < 2N), rsp_fallback=1.
REQ-022 Latency: first-draw accept -> rsp_valid high 3 cycles after acceptance edge; each rejection adds 2 cycles; max 1+2*MAX_TRIES.
REQ-023 DONE: rsp_valid=1; rsp_value and rsp_fallback held stable until the edge with rsp_ready=1, then -> IDLE; no new request accepted in that same cycle.
REQ-024 rsp_ready outside DONE SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-025 rsp_valid and req_ready SHALL never both be 1.
REQ-026 All outputs SHALL be registered or decoded solely from state; no combinational path from lfsr_q, req_* or rsp_ready to any output.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, rsp_valid=0, rsp_value=0x00, rsp_fallback=0, lfsr_en=0, tries=0, latched N and mask=0; req_ready=1 while rst_n=0 is not required (req_ready=0 during reset, 1 from first cycle after release).
REQ-028 Reset in any state, including mid-DRAW or DONE awaiting rsp_ready, SHALL abandon the request with no response produced.

Verification
REQ-029 LFSR (taps 7,5,4,3 shift-left, reset 0xDA) fresh from reset, N=6 -> one lfsr_en pulse, LFSR 0xB5, rsp_value=5, rsp_fallback=0, rsp_valid 3 cycles after accept.
REQ-030 Fresh LFSR, N=5 -> 0xB5&7=5 rejected, 0x6B&7=3 accepted; two lfsr_en pulses, rsp_value=3, rsp_valid 5 cycles after accept.
REQ-031 MAX_TRIES=1, fresh LFSR, N=5 -> one draw, rsp_value=0, rsp_fallback=1.
REQ-032 N=0 and N=1 -> rsp_value=0, no lfsr_en pulse, rsp_valid 1 cycle after accept.
REQ-033 Result held with rsp_ready=0 for 10 cycles -> rsp_value stable, req_ready=0, req_valid pulses ignored; rsp_ready=1 -> IDLE next cycle.
REQ-034 rst_n pulsed low during CHECK -> outputs zero immediately, IDLE after release, no rsp_valid until a new request.
